// File: rtl/dict_loader_if.sv
// Memory-read and dictionary-write bus between the dictionary preloader and its neighbours.
interface dict_loader_if #(
  parameter int unsigned NUM_DICTS     = 3,
  parameter int unsigned MAX_KEY_WIDTH = 8,
  parameter int unsigned MAX_VAL_WIDTH = 15
);
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [31:0]              mem_req_addr;
  logic [31:0]              mem_req_rdata;
  logic [NUM_DICTS-1:0]     dict_write_enable;
  logic [MAX_KEY_WIDTH-1:0] dict_write_index;
  logic [MAX_VAL_WIDTH-1:0] dict_write_val;

  modport master (
    output mem_req_valid, mem_req_addr,
    output dict_write_enable, dict_write_index, dict_write_val,
    input  mem_req_ready, mem_req_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    input  dict_write_enable, dict_write_index, dict_write_val,
    output mem_req_ready, mem_req_rdata
  );
endinterface

// File: rtl/dict_loader.sv
// Dictionary preloader: streams dictionary images from instruction memory into the
// compression dictionaries, then releases the core from reset.
module dict_loader #(
  parameter int unsigned              NUM_DICTS       = 3,
  parameter int unsigned              MAX_KEY_WIDTH   = 8,
  parameter int unsigned              MAX_VAL_WIDTH   = 15,
  parameter logic [8*NUM_DICTS-1:0]   DICT_KEY_WIDTHS = {8'd8, 8'd5, 8'd3},
  parameter logic [8*NUM_DICTS-1:0]   DICT_VAL_WIDTHS = {8'd15, 8'd10, 8'd7},
  parameter logic [31:0]              BASE_ADDR       = 32'h000F_0000,
  parameter bit                       AUTO_START      = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 core_resetn,
  output logic [NUM_DICTS-1:0] format_error,
  output logic [15:0]          entries_loaded,
  dict_loader_if.master        bus
);

  localparam int unsigned PTR_W  = (NUM_DICTS > 1) ? $clog2(NUM_DICTS) : 1;
  localparam int unsigned WPTR_W = 16;

  typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

  state_t                   state, state_d;
  logic                     auto_pend;
  logic [PTR_W-1:0]         dict_ptr, dict_ptr_d;
  logic [MAX_KEY_WIDTH-1:0] index, index_d;
  logic [WPTR_W-1:0]        word_ptr, word_ptr_d;

  logic                     busy_d, done_d, core_resetn_d;
  logic [NUM_DICTS-1:0]     format_error_d;
  logic [15:0]              entries_loaded_d;
  logic                     valid_d;
  logic [31:0]              addr_d;
  logic [NUM_DICTS-1:0]     we_d;
  logic [MAX_KEY_WIDTH-1:0] widx_d;
  logic [MAX_VAL_WIDTH-1:0] wval_d;

  logic [7:0]               key_w_c, val_w_c;
  logic [31:0]              depth_m1_c, val_mask_c;
  logic                     last_in_dict_c, last_dict_c;
  logic [NUM_DICTS-1:0]     onehot_c;

  // Geometry of the dictionary currently being filled.
  always_comb begin
    key_w_c = '0;
    val_w_c = '0;
    for (int k = 0; k < int'(NUM_DICTS); k++) begin
      if (dict_ptr == PTR_W'(k)) begin
        key_w_c = DICT_KEY_WIDTHS[8*k +: 8];
        val_w_c = DICT_VAL_WIDTHS[8*k +: 8];
      end
    end
    depth_m1_c     = (32'd1 << key_w_c) - 32'd1;
    val_mask_c     = 32'((33'd1 << val_w_c) - 33'd1);
    last_in_dict_c = (32'(index) == depth_m1_c);
    last_dict_c    = (dict_ptr == PTR_W'(NUM_DICTS - 1));
    onehot_c       = NUM_DICTS'(1) << dict_ptr;
  end

  always_comb begin
    state_d          = state;
    dict_ptr_d       = dict_ptr;
    index_d          = index;
    word_ptr_d       = word_ptr;
    busy_d           = busy;
    done_d           = done;
    core_resetn_d    = core_resetn;
    format_error_d   = format_error;
    entries_loaded_d = entries_loaded;
    valid_d          = bus.mem_req_valid;
    addr_d           = bus.mem_req_addr;
    we_d             = '0;
    widx_d           = bus.dict_write_index;
    wval_d           = bus.dict_write_val;

    unique case (state)
      IDLE, DONE: begin
        // auto_pend is only ever set while still in IDLE after reset
        if (start || auto_pend) begin
          state_d          = REQ;
          dict_ptr_d       = '0;
          index_d          = '0;
          word_ptr_d       = '0;
          format_error_d   = '0;
          entries_loaded_d = '0;
          busy_d           = 1'b1;
          done_d           = 1'b0;
          core_resetn_d    = 1'b0;
          valid_d          = 1'b1;
          addr_d           = BASE_ADDR;
        end
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          state_d = WRITE;
          valid_d = 1'b0;
          we_d    = onehot_c;
          widx_d  = index;
          wval_d  = MAX_VAL_WIDTH'(bus.mem_req_rdata & val_mask_c);
          if ((bus.mem_req_rdata & ~val_mask_c) != 32'd0)
            format_error_d = format_error | onehot_c;
        end
      end
      WRITE: begin
        entries_loaded_d = entries_loaded + 16'd1;
        word_ptr_d       = word_ptr + 1'b1;
        if (last_in_dict_c) begin
          index_d    = '0;
          dict_ptr_d = dict_ptr + 1'b1;
        end else begin
          index_d = index + 1'b1;
        end
        if (last_in_dict_c && last_dict_c) begin
          state_d       = DONE;
          busy_d        = 1'b0;
          done_d        = 1'b1;
          core_resetn_d = 1'b1;
        end else begin
          state_d = REQ;
          valid_d = 1'b1;
          addr_d  = BASE_ADDR + ((32'(word_ptr) + 32'd1) << 2);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      auto_pend             <= AUTO_START;
      dict_ptr              <= '0;
      index                 <= '0;
      word_ptr              <= '0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      core_resetn           <= 1'b0;
      format_error          <= '0;
      entries_loaded        <= '0;
      bus.mem_req_valid     <= 1'b0;
      bus.mem_req_addr      <= BASE_ADDR;
      bus.dict_write_enable <= '0;
      bus.dict_write_index  <= '0;
      bus.dict_write_val    <= '0;
    end else begin
      state                 <= state_d;
      auto_pend             <= 1'b0;
      dict_ptr              <= dict_ptr_d;
      index                 <= index_d;
      word_ptr              <= word_ptr_d;
      busy                  <= busy_d;
      done                  <= done_d;
      core_resetn           <= core_resetn_d;
      format_error          <= format_error_d;
      entries_loaded        <= entries_loaded_d;
      bus.mem_req_valid     <= valid_d;
      bus.mem_req_addr      <= addr_d;
      bus.dict_write_enable <= we_d;
      bus.dict_write_index  <= widx_d;
      bus.dict_write_val    <= wval_d;
    end
  end

endmodule

// File: tb/tb_dict_loader.sv
// Bench for dict_loader: default 3-dictionary loader plus a 1-dictionary, manual-start variant.
module tb_dict_loader;

  localparam logic [31:0] BASE  = 32'h000F_0000;
  localparam int          TOTAL = 296;
  localparam int          KW [3] = '{3, 5, 8};
  localparam int          VW [3] = '{7, 10, 15};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, start2;
  logic        busy, done, core_resetn;
  logic [2:0]  ferr;
  logic [15:0] cnt;
  logic        busy2, done2, core_resetn2;
  logic [0:0]  ferr2;
  logic [15:0] cnt2;

  dict_loader_if #(.NUM_DICTS(3), .MAX_KEY_WIDTH(8), .MAX_VAL_WIDTH(15)) bus ();
  dict_loader_if #(.NUM_DICTS(1), .MAX_KEY_WIDTH(8), .MAX_VAL_WIDTH(15)) bus2 ();

  dict_loader dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .core_resetn(core_resetn), .format_error(ferr), .entries_loaded(cnt), .bus(bus.master)
  );

  dict_loader #(
    .NUM_DICTS(1), .MAX_KEY_WIDTH(8), .MAX_VAL_WIDTH(15),
    .DICT_KEY_WIDTHS(8'd2), .DICT_VAL_WIDTHS(8'd15), .BASE_ADDR(BASE), .AUTO_START(1'b0)
  ) dut2 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .core_resetn(core_resetn2), .format_error(ferr2), .entries_loaded(cnt2), .bus(bus2.master)
  );

  // Memory model with programmable ready latency
  logic [31:0] img [TOTAL];
  logic [31:0] img2 [4];
  int          lat;
  int          wait_cnt;
  int          woff;

  assign woff = int'((bus.mem_req_addr - BASE) >> 2);
  assign bus.mem_req_ready = bus.mem_req_valid && (wait_cnt >= lat);
  assign bus.mem_req_rdata = (bus.mem_req_ready && woff >= 0 && woff < TOTAL) ? img[woff] : 32'hDEAD_BEEF;
  assign bus2.mem_req_ready = bus2.mem_req_valid;
  assign bus2.mem_req_rdata = img2[bus2.mem_req_addr[3:2]];

  always @(posedge clk)
    wait_cnt <= (bus.mem_req_valid && !bus.mem_req_ready) ? wait_cnt + 1 : 0;

  // Write-port observers and protocol watchers
  logic [31:0] wq [$];
  logic [31:0] wq2 [$];
  int          addr_bad = 0, crn_bad = 0;
  logic        hold_valid = 1'b0;
  logic [31:0] hold_addr;

  always @(negedge clk) begin
    if (|bus.dict_write_enable)
      wq.push_back({6'b0, bus.dict_write_enable, bus.dict_write_index, bus.dict_write_val});
    if (|bus2.dict_write_enable)
      wq2.push_back({8'b0, bus2.dict_write_enable, bus2.dict_write_index, bus2.dict_write_val});
    if (core_resetn !== done) crn_bad++;
    if (hold_valid && bus.mem_req_valid && bus.mem_req_addr !== hold_addr) addr_bad++;
    hold_valid = bus.mem_req_valid && !bus.mem_req_ready;
    hold_addr  = bus.mem_req_addr;
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_crn"},   32'(core_resetn), 32'd0);
    check({tag, "_valid"}, 32'(bus.mem_req_valid), 32'd0);
    check({tag, "_addr"},  bus.mem_req_addr, BASE);
    check({tag, "_wr"},    {6'b0, bus.dict_write_enable, bus.dict_write_index, bus.dict_write_val}, 32'd0);
    check({tag, "_ferr"},  32'(ferr), 32'd0);
    check({tag, "_cnt"},   32'(cnt), 32'd0);
  endtask

  // Called on the first REQ cycle; returns cycles until done, optionally pulsing start mid-load.
  task automatic run_load(input string tag, input int start_at, output int cycles);
    bit pulsed = 1'b0;
    cycles = 0;
    while (!done && cycles < 4000) begin
      if (start_at >= 0 && !pulsed && wq.size() == start_at) begin
        start = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      cycles++;
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] exp_rec(input int k, input int i, input logic [31:0] w);
    return (32'(1 << k) << 23) | (32'(i) << 15) | (w & ((32'd1 << VW[k]) - 32'd1));
  endfunction

  function automatic logic [2:0] model_ferr();
    logic [2:0] f = '0;
    int n = 0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < (1 << KW[k]); i++) begin
        if ((img[n] >> VW[k]) != 32'd0) f[k] = 1'b1;
        n++;
      end
    return f;
  endfunction

  task automatic check_writes(input string tag);
    int n = 0, bad = 0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < (1 << KW[k]); i++) begin
        if (n >= wq.size() || wq[n] !== exp_rec(k, i, img[n])) bad++;
        n++;
      end
    check({tag, "_nwrites"}, 32'(wq.size()), 32'(TOTAL));
    check({tag, "_seq_bad"}, 32'(bad), 32'd0);
    check({tag, "_cnt"}, 32'(cnt), 32'(TOTAL));
    check({tag, "_ferr"}, 32'(ferr), 32'(model_ferr()));
    check({tag, "_idle"}, {30'b0, busy, bus.mem_req_valid}, 32'd0);
  endtask

  initial begin
    int cyc, n, k;
    logic [31:0] last;
    bit found;

    reset = 1'b1; start = 1'b0; start2 = 1'b0; lat = 0;
    for (int i = 0; i < TOTAL; i++) img[i] = 32'(i);
    for (int i = 0; i < 4; i++) img2[i] = $urandom & 32'h0000_7FFF;
    repeat (3) tick();
    check_reset_vals("rst");

    // Auto-start, zero-latency memory, word n = n
    reset = 1'b0;
    tick();
    check("t1_first_req", {bus.mem_req_valid, busy, done, 29'b0}, {3'b110, 29'b0});
    check("t1_first_addr", bus.mem_req_addr, BASE);
    run_load("t1", -1, cyc);
    check("t1_cycles", 32'(cyc), 32'd592);
    check_writes("t1");
    check("t1_d0_i7", wq[7], (32'd1 << 23) | (32'd7 << 15) | 32'd7);
    check("t1_d1_i0", wq[8], (32'd2 << 23) | 32'd8);
    check("t1_d2_i255", wq[295], (32'd4 << 23) | (32'd255 << 15) | 32'd295);
    check("t1_crn", 32'(core_resetn), 32'd1);

    // Reload from DONE with 3-cycle latency, one bad word, and a start pulse mid-load
    lat = 3;
    img[12] = 32'h0000_0C01;
    wq.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_reload", {done, core_resetn, busy, bus.mem_req_valid, 28'b0}, {4'b0011, 28'b0});
    run_load("t2", 100, cyc);
    check("t2_cycles", 32'(cyc), 32'd1480);
    check_writes("t2");
    check("t2_bad_word", wq[12], (32'd2 << 23) | (32'd4 << 15) | 32'd1);
    check("t2_ferr_const", 32'(ferr), 32'd2);

    // Random image with occasional out-of-range words, random latency
    lat = $urandom_range(0, 2);
    n = 0;
    for (int kk = 0; kk < 3; kk++)
      for (int i = 0; i < (1 << KW[kk]); i++) begin
        img[n] = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & ((32'd1 << VW[kk]) - 32'd1));
        n++;
      end
    wq.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_ferr_cleared", 32'(ferr), 32'd0);
    run_load("t3", -1, cyc);
    check("t3_cycles", 32'(cyc), 32'(TOTAL * (2 + lat)));
    check_writes("t3");

    // Reset during dict2 entry 37, held 3 cycles, then auto restart
    lat = 0;
    wq.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 2000) begin
      if (wq.size() > 0) begin
        last = wq[$];
        if (last[25:23] == 3'b100 && last[22:15] == 8'd37) found = 1'b1;
      end
      if (!found) begin
        tick();
        n++;
      end
    end
    check("t4_reached_d2_e37", 32'(found), 32'd1);
    reset = 1'b1;
    start = 1'b1;
    #1;
    check_reset_vals("t4_async");
    for (k = 0; k < 3; k++) tick();
    start = 1'b0;
    check_reset_vals("t4_held");
    wq.delete();
    reset = 1'b0;
    tick();
    check("t4_restart_addr", bus.mem_req_addr, BASE);
    check("t4_restart_valid", 32'(bus.mem_req_valid), 32'd1);
    run_load("t4", -1, cyc);
    check("t4_cycles", 32'(cyc), 32'd592);
    check_writes("t4");

    check("addr_stable", 32'(addr_bad), 32'd0);
    check("crn_tracks_done", 32'(crn_bad), 32'd0);

    // Single 4-entry dictionary, manual start only
    check("d2_idle", {29'b0, busy2, bus2.mem_req_valid, core_resetn2}, 32'd0);
    check("d2_no_writes", 32'(wq2.size()), 32'd0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("d2_done", {30'b0, done2, core_resetn2}, 32'd3);
    check("d2_cycles", 32'(cyc), 32'd8);
    check("d2_nwrites", 32'(wq2.size()), 32'd4);
    n = 0;
    for (int i = 0; i < 4; i++)
      if (i >= wq2.size() || wq2[i] !== ((32'd1 << 23) | (32'(i) << 15) | img2[i])) n++;
    check("d2_seq_bad", 32'(n), 32'd0);
    check("d2_cnt", 32'(cnt2), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dict_loader.md
Name: dict_loader

Overview:
- Hardware dictionary preloader for the code-compression controller. Replaces the bench-side loop that pushes field dictionaries into the controller.
- Fetches NUM_DICTS dictionary images word by word from instruction memory over the imem valid/ready interface. Writes each entry into its dictionary, then releases the core from reset.
- Generalises the fixed 3-field, 3/5/8-bit-key scheme to a parametrised dictionary count and per-dictionary key/value widths. Adds re-load on command, format checking and progress reporting.

Parameters:
- NUM_DICTS, 3, number of dictionaries (1..8).
- MAX_KEY_WIDTH, 8, width of dict_write_index; every per-dictionary key width must be ≤ this.
- MAX_VAL_WIDTH, 15, width of the shared dict_write_val bus.
- DICT_KEY_WIDTHS, {8'd8,8'd5,8'd3}, packed 8 bits per dictionary, dict 0 in bits [7:0]; depth of dict k = 2**KEY_WIDTH[k].
- DICT_VAL_WIDTHS, {8'd15,8'd10,8'd7}, packed 8 bits per dictionary; value width of dict k.
- BASE_ADDR, 32'h000F_0000, byte address of the dict 0 entry 0 word. Images are contiguous: dict 0 first, then dict 1, and so on.
- AUTO_START, 1, 1 = begin loading on the first cycle after reset deasserts.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a (re)load when not busy
- busy  out  1  load in progress
- done  out  1  all dictionaries loaded; sticky until next load or reset
- core_resetn  out  1  active-low reset to picorv32; low whenever done=0
- mem_req_valid  out  1  memory read request
- mem_req_ready  in  1  memory response valid, same cycle as rdata
- mem_req_addr  out  32  word-aligned read address
- mem_req_rdata  in  32  read data
- dict_write_enable  out  NUM_DICTS  one-hot write strobe, bit k = dict k
- dict_write_index  out  MAX_KEY_WIDTH  entry index, zero-extended
- dict_write_val  out  MAX_VAL_WIDTH  entry value, zero-extended from the dict's value width
- format_error  out  NUM_DICTS  sticky; bit k set if any dict k word had nonzero bits at or above its value width
- entries_loaded  out  16  count of entries written during the current load

Behaviour:
- Reset values: busy=0, done=0, core_resetn=0, mem_req_valid=0, mem_req_addr=BASE_ADDR, dict_write_enable=0, dict_write_index=0, dict_write_val=0, format_error=0, entries_loaded=0. State is IDLE.
- FSM states: IDLE, REQ, WRITE, DONE.
- IDLE → REQ:
  - on the first clk edge after reset deasserts if AUTO_START=1, or
  - on start=1.
  - On entry: dict ptr=0, index=0, word ptr=0, format_error cleared, entries_loaded cleared.
- REQ:
  - mem_req_valid=1 and mem_req_addr=BASE_ADDR+4*word_ptr, both held stable until mem_req_ready.
  - On ready: capture rdata and go to WRITE.
  - mem_req_valid drops the cycle after ready is seen.
- WRITE (exactly one cycle):
  - dict_write_enable[dict_ptr]=1, dict_write_index=index, dict_write_val=rdata[val_w-1:0] zero-extended.
  - If rdata[31:val_w] is nonzero, set format_error[dict_ptr]; the entry is still written, truncated.
  - entries_loaded increments and word_ptr increments.
  - If index == depth-1: index=0 and dict_ptr increments. Otherwise index increments.
  - Next state is DONE if that was the last entry of the last dict, else REQ.
- DONE:
  - done=1, busy=0, core_resetn=1 starting the cycle after the final WRITE.
  - start=1 in DONE begins a reload: done and core_resetn drop the next cycle and the FSM re-enters REQ with pointers cleared.
- busy=1 in REQ and WRITE. start is ignored while busy.
- Throughput is 2 cycles per entry when ready is asserted in the same cycle as valid. Each cycle of ready latency adds one cycle per entry.
- Total entries = sum of 2**KEY_WIDTH[k]. With default parameters: 8+32+256 = 296 entries, 1184 bytes, last address BASE_ADDR+0x49C.
- Reset asserted mid-load aborts immediately: all outputs return to reset values, no partial done. With AUTO_START=1 the load restarts from entry 0 after deassertion.
- Simultaneous start and reset: reset wins.
- Dictionary contents are not read back; correctness is verified via the write port.

Test Plan:
- Defaults, zero-latency memory (ready same cycle as valid), image word n = n: 296 writes. dict0 indices 0..7 get values 0..7; dict1 index 0 gets 8; dict2 index 255 gets 295 & 0x7FFF. done rises 592 cycles after the first REQ cycle; entries_loaded=296; core_resetn rises with done.
- Memory with 3-cycle ready latency: address held stable while waiting; load takes 296*5 = 1480 cycles; write sequence identical to the previous test.
- dict1 entry 4 word = 32'h0000_0C01 (10-bit width): dict_write_val=10'h001 written; format_error=3'b010 after done; other dicts unaffected.
- start pulsed mid-load at entry 100: ignored; load completes normally. start pulsed in DONE: done drops, full 296-entry reload runs, format_error cleared.
- reset asserted during dict2 entry 37, held 3 cycles: all outputs return to reset values; after release, the load restarts at BASE_ADDR with entry 0 of dict0 (AUTO_START=1).
- NUM_DICTS=1, DICT_KEY_WIDTHS=8'd2, DICT_VAL_WIDTHS=8'd15, AUTO_START=0: idle until start; then exactly 4 writes, indices 0..3; done asserted afterwards.
